// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - 8-bit constant to 5-bit immediate field encoder (optional stats: IMM_ENCODER_STATS_EN)
module imm_encoder #(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic [1:0]        out_kind,
    output logic              out_last
`ifdef IMM_ENCODER_STATS_EN
    ,
    output logic [7:0]        long_count
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EMIT_SHORT = 2'd1,
        EMIT_HI    = 2'd2,
        EMIT_LO    = 2'd3
    } state_t;

    localparam logic [1:0] KIND_SHORT = 2'b00;
    localparam logic [1:0] KIND_HI    = 2'b01;
    localparam logic [1:0] KIND_LO    = 2'b10;

    state_t            state;
    logic [DATA_W-1:0] const_q;
    logic              fits_short;

    // A constant fits a sign-extended 5-bit field when bits [7:4] all match the sign.
    assign fits_short = (in_data[7:4] == 4'h0) || (in_data[7:4] == 4'hF);
    assign in_ready   = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            const_q   <= '0;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_kind  <= KIND_SHORT;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        const_q   <= in_data;
                        out_valid <= 1'b1;
                        if (fits_short) begin
                            state    <= EMIT_SHORT;
                            out_imm  <= in_data[4:0];
                            out_kind <= KIND_SHORT;
                            out_last <= 1'b1;
                        end else begin
                            state    <= EMIT_HI;
                            out_imm  <= in_data[7:3];
                            out_kind <= KIND_HI;
                            out_last <= 1'b0;
                        end
                    end
                end
                EMIT_SHORT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                EMIT_HI: begin
                    if (out_ready) begin
                        state    <= EMIT_LO;
                        out_imm  <= {2'b00, const_q[2:0]};
                        out_kind <= KIND_LO;
                        out_last <= 1'b1;
                    end
                end
                EMIT_LO: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_ENCODER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            long_count <= 8'h00;
        end else if ((state == EMIT_HI) && out_ready && (long_count != 8'hFF)) begin
            long_count <= long_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard testbench for imm_encoder
module tb_imm_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_imm;
    logic [1:0] out_kind;
    logic       out_last;
`ifdef IMM_ENCODER_STATS_EN
    logic [7:0] long_count;
`endif

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_kind  (out_kind),
        .out_last  (out_last)
`ifdef IMM_ENCODER_STATS_EN
        ,
        .long_count(long_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int short_seen = 0;
    int long_seen = 0;
    bit rand_ready = 1'b0;

    logic [7:0] exp_q[$];   // {imm, kind, last}
    logic [7:0] dec_q[$];
    logic [4:0] hi_seen = 5'd0;

    function automatic logic [7:0] fld(input logic [4:0] imm, input logic [1:0] kind, input logic last);
        return {imm, kind, last};
    endfunction

    // Expected encoding derived from the signed range, not from the bit test.
    task automatic push_expected(input logic [7:0] v);
        int sv;
        sv = int'($signed(v));
        if (sv >= -16 && sv <= 15) begin
            exp_q.push_back(fld(v[4:0], 2'b00, 1'b1));
        end else begin
            exp_q.push_back(fld(v[7:3], 2'b01, 1'b0));
            exp_q.push_back(fld({2'b00, v[2:0]}, 2'b10, 1'b1));
        end
    endtask

    // Scoreboard: pops an expected field on every output handshake and decodes complete constants.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [7:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL field_unexpected: got imm=%b kind=%b last=%b, required none", out_imm, out_kind, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_imm, out_kind, out_last} !== e)
                    $display("FAIL field: got imm=%b kind=%b last=%b, required imm=%b kind=%b last=%b",
                             out_imm, out_kind, out_last, e[7:3], e[2:1], e[0]);
                else
                    passed++;
            end
            if (out_kind == 2'b01) hi_seen = out_imm;
            if (out_kind == 2'b00) begin
                dec_q.push_back({{3{out_imm[4]}}, out_imm});
                short_seen++;
            end
            if (out_kind == 2'b10) begin
                dec_q.push_back({hi_seen, 3'b000} | {5'b00000, out_imm[2:0]});
                long_seen++;
            end
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            passed++;
            push_expected(v);
            in_valid = 1'b1;
            in_data  = v;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        bit done;
        done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) done = 1'b1;
            else begin
                @(posedge clk); #1;
                if (rand_ready) out_ready = 1'($urandom_range(0, 1));
                n++;
            end
        end
        checks++;
        if (!done) $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
        else passed++;
        out_ready = 1'b1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        dec_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_imm, out_kind, out_last} !== 10'b10_00000_00_0)
            $display("FAIL reset_state: got ready=%b valid=%b imm=%b kind=%b last=%b, required 1 0 00000 00 0",
                     in_ready, out_valid, out_imm, out_kind, out_last);
        else passed++;
    endtask

    task automatic test_short();
        logic [7:0] vals[4];
        logic [7:0] got;
        vals = '{8'h05, 8'hF3, 8'hF0, 8'h0F};
        out_ready = 1'b1;
        foreach (vals[i]) begin
            dec_q.delete();
            send(vals[i]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) $display("FAIL short_latency: out_valid=%b, required 1", out_valid);
            else passed++;
            wait_idle();
            checks++;
            got = (dec_q.size() == 1) ? dec_q[0] : 8'hxx;
            if (got !== vals[i]) $display("FAIL short_decode: got %h, required %h", got, vals[i]);
            else passed++;
            checks++;
            if (in_ready !== 1'b1) $display("FAIL short_ready_after: in_ready=%b, required 1", in_ready);
            else passed++;
        end
    endtask

    task automatic test_long();
        logic [7:0] vals[3];
        logic [7:0] got;
        vals = '{8'hA7, 8'h10, 8'hEF};
        out_ready = 1'b1;
        foreach (vals[i]) begin
            dec_q.delete();
            send(vals[i]);
            wait_idle();
            checks++;
            got = (dec_q.size() == 1) ? dec_q[0] : 8'hxx;
            if (got !== vals[i]) $display("FAIL long_decode: got %h, required %h", got, vals[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'h40);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_imm, out_kind, out_last, in_ready} !== 10'b1_01000_01_0_0)
                $display("FAIL hold_hi: got valid=%b imm=%b kind=%b last=%b ready=%b, required 1 01000 01 0 0",
                         out_valid, out_imm, out_kind, out_last, in_ready);
            else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        out_ready = 1'b1;
        dec_q.delete();
        send(8'h03);
        t0 = $time;
        send(8'h04);
        t1 = $time;
        checks++;
        if (t1 - t0 != 20) $display("FAIL short_throughput: got %0d ns, required 20 ns", t1 - t0);
        else passed++;
        send(8'h55);
        t0 = $time;
        send(8'h66);
        t1 = $time;
        checks++;
        if (t1 - t0 != 30) $display("FAIL long_throughput: got %0d ns, required 30 ns", t1 - t0);
        else passed++;
        wait_idle();
    endtask

    task automatic test_sweep();
        apply_reset();
        short_seen = 0;
        long_seen  = 0;
        rand_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            wait_idle();
        end
        rand_ready = 1'b0;
        for (int v = 0; v < 256; v++) begin
            checks++;
            if (v >= dec_q.size() || dec_q[v] !== 8'(v))
                $display("FAIL sweep_decode: index %0d got %h, required %h", v,
                         (v < dec_q.size()) ? dec_q[v] : 8'hxx, 8'(v));
            else passed++;
        end
        checks++;
        if (short_seen != 32 || long_seen != 224)
            $display("FAIL sweep_counts: got short=%0d long=%0d, required 32 224", short_seen, long_seen);
        else passed++;
`ifdef IMM_ENCODER_STATS_EN
        checks++;
        if (long_count !== 8'hE0) $display("FAIL long_count: got %h, required e0", long_count);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(8'h80);
        @(negedge clk);
        checks++;
        if ({out_valid, out_imm, out_kind} !== 8'b1_10000_01)
            $display("FAIL mid_hi: got valid=%b imm=%b kind=%b, required 1 10000 01", out_valid, out_imm, out_kind);
        else passed++;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        dec_q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'h01);
        wait_idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dec_q.size() != 1 || dec_q[0] !== 8'h01 || out_valid !== 1'b0)
            $display("FAIL mid_no_stale: got fields=%0d valid=%b, required 1 field 01 and valid 0", dec_q.size(), out_valid);
        else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
